// File: rtl/uart_pkg.sv
// Shared UART register map and TX sequencer state encoding.
package uart_pkg;

    localparam logic [2:0]  UART_REG_DATA         = 3'd0;
    localparam logic [2:0]  UART_REG_STATUS       = 3'd4;
    localparam logic [31:0] UART_STATUS_IDLE_MASK = 32'h0000_6000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with a combinational head; DEPTH must be a power of 2.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter of NREQ byte streams into a TX FIFO, drained into the UART
// data register only after a fresh idle status read.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NREQ        = 2,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] STATUS_MASK = UART_STATUS_IDLE_MASK
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [8*NREQ-1:0]             req_data_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic [2:0]                    u_addr_o,
    output logic [31:0]                   u_din_o,
    input  logic [31:0]                   u_dout_i,
    output logic                          u_wr_o,
    output logic                          u_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] rr_q;
    logic [PW-1:0] rr_d;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic [7:0]    push_data;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_head;

    seq_state_e    state_q;
    logic          hold_cnt_q;
    logic [2:0]    u_addr_q;
    logic [31:0]   u_din_q;
    logic          u_wr_q;
    logic          u_valid_q;

    // Search offsets upward from rr_q; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!grant_found && req_valid_i[j] && (j == (int'(rr_q) + k) % NREQ)) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(j);
                end
            end
        end
    end

    always_comb begin
        push_data = 8'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_idx == PW'(j)) push_data = req_data_i[8*j +: 8];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready_o[gi] = grant_found && !fifo_full && (grant_idx == PW'(gi));
    end

    assign push = grant_found && !fifo_full;
    assign rr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else if (push) begin
            rr_q <= rr_d;
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count_o)
    );

    assign pop = (state_q == S_WRITE);

    // Bus outputs default to a status read; only the CHECK->WRITE edge loads a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= 1'b0;
            u_addr_q   <= UART_REG_STATUS;
            u_din_q    <= 32'd0;
            u_wr_q     <= 1'b0;
            u_valid_q  <= 1'b0;
        end else begin
            u_addr_q  <= UART_REG_STATUS;
            u_din_q   <= 32'd0;
            u_wr_q    <= 1'b0;
            u_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if ((u_dout_i & STATUS_MASK) != 32'd0) begin
                        state_q   <= S_WRITE;
                        u_addr_q  <= UART_REG_DATA;
                        u_din_q   <= {24'd0, fifo_head};
                        u_wr_q    <= 1'b1;
                        u_valid_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q    <= S_HOLD;
                    hold_cnt_q <= 1'b0;
                end
                S_HOLD: begin
                    // Status read back here still reflects the pre-write idle state.
                    if (hold_cnt_q) begin
                        hold_cnt_q <= 1'b0;
                        state_q    <= fifo_empty ? S_IDLE : S_CHECK;
                    end else begin
                        hold_cnt_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign u_addr_o  = u_addr_q;
    assign u_din_o   = u_din_q;
    assign u_wr_o    = u_wr_q;
    assign u_valid_o = u_valid_q;
    assign busy_o    = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART status/frame model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [2:0]  u_addr;
    logic [31:0] u_din;
    logic [31:0] u_dout = 32'd0;
    logic        u_wr;
    logic        u_valid;
    logic [3:0]  fifo_count;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ        (2),
        .FIFO_DEPTH  (8),
        .STATUS_MASK (32'h0000_6000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .u_addr_o     (u_addr),
        .u_din_o      (u_din),
        .u_dout_i     (u_dout),
        .u_wr_o       (u_wr),
        .u_valid_o    (u_valid),
        .fifo_count_o (fifo_count),
        .busy_o       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART model: goes busy two cycles after a data write, status registered.
    int cyc        = 0;
    int busy_cnt   = 0;
    bit pend       = 1'b0;
    bit force_busy = 1'b0;
    bit gate_mode  = 1'b0;
    int frame_len  = 20;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        pend <= u_valid && u_wr && (u_addr == 3'd0);
        if (pend) busy_cnt <= frame_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        u_dout <= ((u_addr == 3'd4) && (busy_cnt == 0) && !force_busy &&
                   (!gate_mode || (cyc % 4340 == 0))) ? 32'h0000_6000 : 32'h0;
    end

    logic [7:0]  wr_q[$];
    logic [7:0]  acc_q[$];
    logic [31:0] prev_dout   = 32'd0;
    int          last_wr_cyc = -100;

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (u_valid || u_wr) begin
                check_eq("wr_strobe_pair", 32'(u_wr), 32'(u_valid));
                check_eq("wr_addr", 32'(u_addr), 32'd0);
                check_eq("wr_din_hi", 32'(u_din[31:8]), 32'd0);
                check_eq("wr_fresh_idle", 32'((prev_dout & 32'h6000) != 0), 32'd1);
                check_eq("wr_overrun", 32'((busy_cnt != 0) || pend), 32'd0);
                check_eq("wr_spacing", 32'((cyc - last_wr_cyc) >= 3), 32'd1);
                $display("write byte %02h at cycle %0d", u_din[7:0], cyc);
                wr_q.push_back(u_din[7:0]);
                last_wr_cyc = cyc;
            end else begin
                check_eq("idle_din", u_din, 32'd0);
            end
            for (int j = 0; j < 2; j++) begin
                if (req_valid[j] && req_ready[j]) acc_q.push_back(req_data[8*j +: 8]);
            end
        end
        prev_dout = u_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        wr_q.delete();
        acc_q.delete();
    endtask

    task automatic push0(input logic [7:0] b);
        req_valid = 2'b01;
        req_data  = {8'h00, b};
        @(negedge clk);
        check_eq("push_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
    endtask

    task automatic wait_writes(input int n, input int bound);
        for (int k = 0; k < bound && wr_q.size() < n; k++) @(posedge clk);
        #1;
        check_eq("write_count", 32'(wr_q.size()), 32'(n));
    endtask

    task automatic wait_strobe(input int bound);
        for (int k = 0; k < bound && !u_valid; k++) tick();
        check_eq("strobe_seen", 32'(u_valid), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] b0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = b0 + 8'(i);
            check_eq(tag, (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(e));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_rr [6];
    logic [1:0] got;
    int         na, nb;

    initial begin
        exp_rr = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        rst = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'd0;

        // Reset values while reset is held.
        @(negedge clk);
        check_eq("rst_addr", 32'(u_addr), 32'd4);
        check_eq("rst_din", u_din, 32'd0);
        check_eq("rst_wr", 32'(u_wr), 32'd0);
        check_eq("rst_valid", 32'(u_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single byte: push at edge 0, strobe during cycle 2-3, idle after HOLD.
        req_valid = 2'b01;
        req_data  = 16'h0041;
        @(negedge clk);
        check_eq("sb_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("sb_count_e0", 32'(fifo_count), 32'd1);
        check_eq("sb_busy_e0", 32'(busy), 32'd1);
        check_eq("sb_valid_e0", 32'(u_valid), 32'd0);
        @(negedge clk);
        check_eq("sb_valid_e1", 32'(u_valid), 32'd0);
        @(negedge clk);
        check_eq("sb_valid_e2", 32'(u_valid), 32'd1);
        check_eq("sb_wr_e2", 32'(u_wr), 32'd1);
        check_eq("sb_addr_e2", 32'(u_addr), 32'd0);
        check_eq("sb_din_e2", u_din, 32'h41);
        @(negedge clk);
        check_eq("sb_valid_e3", 32'(u_valid), 32'd0);
        check_eq("sb_addr_e3", 32'(u_addr), 32'd4);
        check_eq("sb_count_e3", 32'(fifo_count), 32'd0);
        check_eq("sb_busy_e3", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("sb_busy_e4", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("sb_busy_e5", 32'(busy), 32'd0);
        check_eq("sb_nwrites", 32'(wr_q.size()), 32'd1);

        // Round-robin between two continuously valid requesters.
        do_reset();
        frame_len = 30;
        na = 0;
        nb = 0;
        for (int k = 0; k < 50 && (na + nb) < 6; k++) begin
            req_valid = {nb < 3, na < 3};
            req_data  = {8'hB0 + 8'(nb), 8'hA0 + 8'(na)};
            @(negedge clk);
            got = req_valid & req_ready;
            tick();
            if (got[0]) na++;
            if (got[1]) nb++;
        end
        req_valid = 2'b00;
        check_eq("rr_accepted", 32'(acc_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check_eq("rr_accept_order", (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));
        wait_writes(6, 2000);
        for (int i = 0; i < 6; i++)
            check_eq("rr_write_order", (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));

        // FIFO full with the UART held busy.
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_valid = 2'b01;
            req_data  = {8'h00, 8'h10 + 8'(i)};
            @(negedge clk);
            if (i < 8) begin
                check_eq("full_ready", 32'(req_ready), 32'd1);
            end else begin
                check_eq("full_ready9", 32'(req_ready), 32'd0);
                check_eq("full_count", 32'(fifo_count), 32'd8);
            end
            tick();
        end
        req_valid = 2'b00;
        repeat (5) tick();
        check_eq("full_nowrite", 32'(wr_q.size()), 32'd0);
        force_busy = 1'b0;
        wait_writes(8, 2000);
        check_writes("full_drain", 8'h10, 8);

        // Push coinciding with the S_WRITE pop.
        do_reset();
        force_busy = 1'b1;
        push0(8'hC0);
        push0(8'hC1);
        push0(8'hC2);
        @(negedge clk);
        check_eq("pp_count_pre", 32'(fifo_count), 32'd3);
        tick();
        force_busy = 1'b0;
        wait_strobe(100);
        req_valid = 2'b01;
        req_data  = 16'h00C3;
        @(negedge clk);
        check_eq("pp_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("pp_count_post", 32'(fifo_count), 32'd3);
        wait_writes(4, 2000);
        check_writes("pp_order", 8'hC0, 4);

        // Reset mid-queue with a frame in flight.
        do_reset();
        frame_len  = 200;
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) push0(8'hD0 + 8'(i));
        force_busy = 1'b0;
        wait_strobe(100);
        tick();
        check_eq("rq_count_pre", 32'(fifo_count), 32'd5);
        rst = 1'b1;
        #1;
        check_eq("rq_addr", 32'(u_addr), 32'd4);
        check_eq("rq_valid", 32'(u_valid), 32'd0);
        check_eq("rq_wr", 32'(u_wr), 32'd0);
        check_eq("rq_din", u_din, 32'd0);
        check_eq("rq_count", 32'(fifo_count), 32'd0);
        check_eq("rq_busy", 32'(busy), 32'd0);
        check_eq("rq_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        push0(8'h55);
        repeat (20) tick();
        check_eq("rq_waits_idle", 32'(wr_q.size()), 32'd1);
        wait_writes(2, 1000);
        check_eq("rq_first", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'hD0);
        check_eq("rq_new", (wr_q.size() > 1) ? 32'(wr_q[1]) : 32'hFFFF_FFFF, 32'h55);

        // Status gating: idle reported one cycle in 4340.
        do_reset();
        frame_len = 10;
        gate_mode = 1'b1;
        push0(8'hE0);
        push0(8'hE1);
        wait_writes(2, 10000);
        check_writes("gate_order", 8'hE0, 2);
        gate_mode = 1'b0;
        repeat (6) tick();
        check_eq("gate_busy_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NREQ byte-stream requesters, such as the CPU console path and the debug monitor.
- Grants requesters round-robin into a small TX FIFO.
- A sequencer drains the FIFO into the UART register port. It polls the UART status register and writes the data register only when the transmitter reports idle.
- Sits between the requesters and the UART bus slave port (addr/din/dout/wr/valid).

Parameters:
- NREQ, 2, number of requesters (2..4).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2.
- STATUS_MASK, 32'h0000_6000, status bits that indicate transmitter idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte.
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot accept; byte i is transferred when req_valid[i] & req_ready[i].
- u_addr  out  3  UART register address: 3'd0 = data, 3'd4 = status.
- u_din  out  32  UART write data, {24'd0, byte}.
- u_dout  in  32  UART read data; registered in the UART, valid one cycle after u_addr.
- u_wr  out  1  UART write strobe.
- u_valid  out  1  UART access strobe.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FIFO non-empty or sequencer not in S_IDLE.

Behaviour:
- Reset values (asynchronous):
  - FIFO empty, fifo_count=0, rr pointer=0, state S_IDLE.
  - u_addr=3'd4, u_din=0, u_wr=0, u_valid=0, busy=0.
- Arbitration (combinational):
  - When the FIFO is not full, grant the first requester with req_valid set, searching from (last_grant+1) mod NREQ upward.
  - req_ready asserts only for that requester. At most one push per cycle.
  - last_grant updates only on an accepted push.
  - When the FIFO is full, req_ready=0.
  - Push is not combinationally dependent on a same-cycle pop (ready uses !full only).
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head byte is visible combinationally.
- Sequencer states (u_addr=3'd4 in every state except S_WRITE):
  - S_IDLE: go to S_CHECK when the FIFO is non-empty.
  - S_CHECK:
    - Sample u_dout. u_addr has already been 3'd4 for ≥1 cycle on entry because the prior state drove it.
    - If (u_dout & STATUS_MASK) != 0, go to S_WRITE. Otherwise stay in S_CHECK.
  - S_WRITE:
    - Drive u_addr=3'd0, u_din={24'd0, head}, u_valid=1, u_wr=1 for exactly one cycle.
    - Pop the FIFO. Go to S_HOLD.
  - S_HOLD:
    - 2 cycles, counted by an internal 1-bit counter. Masks the stale status read-back while the UART leaves its idle state.
    - Then go to S_CHECK if the FIFO is non-empty, otherwise S_IDLE.
- Timing:
  - Minimum push-to-write latency with the UART idle is 3 cycles: push at edge 0, S_CHECK at edge 1, S_WRITE at edge 2, strobe visible during cycle 2–3.
  - Back-to-back bytes: the next S_WRITE occurs only after the UART status returns to idle. The UART frame time is therefore the throughput limit.
- u_valid and u_wr are never high outside S_WRITE. u_din is held at 0 outside S_WRITE.
- Reset mid-operation:
  - All state clears immediately and queued bytes are discarded.
  - The UART has no reset, so a frame already in flight completes.
  - The first post-reset write waits in S_CHECK until idle is reported. This is required: no write may be issued without a fresh idle status sample.
- busy is combinational from state and the FIFO empty flag.

Decomposition:
- Package uart_pkg:
  - Register offsets UART_REG_DATA=3'd0 and UART_REG_STATUS=3'd4.
  - UART_STATUS_IDLE_MASK=32'h6000.
  - Sequencer state encoding: S_IDLE, S_CHECK, S_WRITE, S_HOLD, 2 bits.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO, 8-bit wide, parameter DEPTH.
  - Ports: push/pop/din/dout/empty/full/count; async reset.
- The arbiter and sequencer live in uart_tx_arbiter.

Test Plan:
- Single byte:
  - Stimulus: req0 pushes 8'h41; UART model reports idle (dout=32'h6000).
  - Required: exactly one write with u_addr=0, u_din=32'h41, u_wr=u_valid=1, 3 cycles after the push.
  - Then busy=0 after S_HOLD.
- Round-robin:
  - Stimulus: req0 and req1 both continuously valid with bytes 8'hA0.. and 8'hB0...
  - Required: accept order A0,B0,A1,B1,...
  - UART writes occur in that order, each only after the model returns status 32'h6000.
- FIFO full:
  - Stimulus: UART model held busy (dout=0); push 9 bytes from req0.
  - Required: 8 accepted, fifo_count=8, req_ready=0 on the 9th, no UART write.
  - On release of the busy model, bytes drain in order.
- Status gating:
  - Stimulus: UART model idle for only 1 cycle every 434*10 cycles.
  - Required: no write while dout&6000==0.
  - Every write has ≥3 cycles of spacing and none is issued during the HOLD masking window.
- Reset mid-queue:
  - Stimulus: 5 bytes queued and one write just issued; assert rst for 2 cycles.
  - Required: all outputs take their reset values immediately; fifo_count=0.
  - A new byte 8'h55 is written only after a fresh idle status.
- Simultaneous push/pop:
  - Stimulus: FIFO holds 3 bytes; a push coincides with the S_WRITE pop.
  - Required: fifo_count stays 3 and order is preserved.
